// File: rtl/simt_warp_pc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : simt_warp_pc_unit
//  Purpose  : Per-warp program counter unit for a SIMT datapath. It holds one
//             shared PC, an active-lane mask and a divergence/reconvergence
//             stack. Divergent branch paths are run one after the other, and
//             the full mask is restored at the reconvergence PC.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1        clock, all state updates on posedge
//    rst             in   1        synchronous active-high reset
//    i_adv           in   1        current instruction retires this cycle
//    i_br_valid      in   1        current instruction is a conditional branch
//    i_br_taken      in   LANES    per-lane branch outcome (masked internally)
//    i_br_target     in   32       branch target PC
//    i_reconv_pc     in   32       reconvergence PC of this branch
//    i_jmp_valid     in   1        uniform jump / jr
//    i_jmp_target    in   32       jump target
//    i_halt_req      in   1        current instruction is halt
//    o_pc            out  32       fetch PC
//    o_active_mask   out  LANES    lanes enabled for writeback
//    o_depth         out  DW       occupied stack entries
//    o_halted        out  1        sticky halt
//    o_overflow      out  1        sticky divergence-stack overflow
// ============================================================================
module simt_warp_pc_unit #(
  parameter int          LANES       = 4,
  parameter int          STACK_DEPTH = 8,
  parameter logic [31:0] PC_INIT     = 32'h0000_0000,
  localparam int         DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_adv,
  input  logic             i_br_valid,
  input  logic [LANES-1:0] i_br_taken,
  input  logic [31:0]      i_br_target,
  input  logic [31:0]      i_reconv_pc,
  input  logic             i_jmp_valid,
  input  logic [31:0]      i_jmp_target,
  input  logic             i_halt_req,
  output logic [31:0]      o_pc,
  output logic [LANES-1:0] o_active_mask,
  output logic [DW-1:0]    o_depth,
  output logic             o_halted,
  output logic             o_overflow
);

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // Architectural state
  logic [31:0]      r_pc;
  logic [LANES-1:0] r_mask;
  logic [31:0]      r_rpc;
  logic             r_rpc_vld;
  logic [DW-1:0]    r_depth;
  logic             r_halted;
  logic             r_overflow;

  // Divergence stack, one array per entry field
  logic [31:0]      r_stk_pc   [0:STACK_DEPTH-1];
  logic [LANES-1:0] r_stk_mask [0:STACK_DEPTH-1];
  logic [31:0]      r_stk_rpc  [0:STACK_DEPTH-1];
  logic             r_stk_vld  [0:STACK_DEPTH-1];

  logic [31:0]      w_pc_plus4;
  logic [LANES-1:0] w_taken;
  logic [LANES-1:0] w_ntaken;
  logic             w_room;
  logic [31:0]      w_npc;
  logic [LANES-1:0] w_nm;
  logic             w_diverge;
  logic             w_ovf_hit;
  logic             w_halt_hit;
  logic [31:0]      w_eff_rpc;
  logic             w_eff_vld;
  logic [DW-1:0]    w_eff_depth;
  logic             w_pop;
  logic [AW-1:0]    w_idx_a;
  logic [AW-1:0]    w_idx_b;
  logic [AW-1:0]    w_idx_top;
  logic [31:0]      w_top_pc;
  logic [LANES-1:0] w_top_mask;
  logic [31:0]      w_top_rpc;
  logic             w_top_vld;
  logic             w_retire;

  assign w_retire   = i_adv && !r_halted;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_taken    = i_br_taken & r_mask;
  assign w_ntaken   = r_mask & ~w_taken;
  assign w_room     = (int'(r_depth) + 2) <= STACK_DEPTH;

  // Push slots for a divergence: restore entry below, not-taken path on top.
  assign w_idx_a    = AW'(r_depth);
  assign w_idx_b    = AW'(r_depth + DW'(1));
  assign w_idx_top  = AW'(r_depth - DW'(1));

  // Candidate next PC / mask from the retiring instruction.
  always_comb begin
    w_npc      = w_pc_plus4;
    w_nm       = r_mask;
    w_diverge  = 1'b0;
    w_ovf_hit  = 1'b0;
    w_halt_hit = 1'b0;
    if (i_halt_req) begin
      w_halt_hit = 1'b1;
    end else if (i_jmp_valid) begin
      w_npc = i_jmp_target;
    end else if (i_br_valid) begin
      if (w_taken == '0) begin
        w_npc = w_pc_plus4;
      end else if (w_ntaken == '0) begin
        w_npc = i_br_target;
      end else if (w_room) begin
        w_diverge = 1'b1;
        w_npc     = i_br_target;
        w_nm      = w_taken;
      end else begin
        w_ovf_hit = 1'b1;
      end
    end
  end

  // Reconvergence is judged against the state as it stands after a
  // divergence in the same cycle, so a branch whose target equals its own
  // reconvergence PC immediately falls through to the not-taken path.
  assign w_eff_rpc   = w_diverge ? i_reconv_pc : r_rpc;
  assign w_eff_vld   = w_diverge | r_rpc_vld;
  assign w_eff_depth = w_diverge ? (r_depth + DW'(2)) : r_depth;
  assign w_pop       = w_eff_vld && (w_npc == w_eff_rpc) && (w_eff_depth != '0);

  // The entry being popped is either the one just pushed this cycle (not
  // yet in the array) or the current top of the stack.
  always_comb begin
    if (w_diverge) begin
      w_top_pc   = w_pc_plus4;
      w_top_mask = w_ntaken;
      w_top_rpc  = i_reconv_pc;
      w_top_vld  = 1'b1;
    end else begin
      w_top_pc   = r_stk_pc[w_idx_top];
      w_top_mask = r_stk_mask[w_idx_top];
      w_top_rpc  = r_stk_rpc[w_idx_top];
      w_top_vld  = r_stk_vld[w_idx_top];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= PC_INIT;
      r_mask     <= '1;
      r_rpc      <= '0;
      r_rpc_vld  <= 1'b0;
      r_depth    <= '0;
      r_halted   <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_retire) begin
      if (w_halt_hit) begin
        r_halted <= 1'b1;
      end else if (w_ovf_hit) begin
        // Not enough room for two entries: freeze instead of corrupting.
        r_overflow <= 1'b1;
        r_halted   <= 1'b1;
      end else if (w_pop) begin
        r_pc      <= w_top_pc;
        r_mask    <= w_top_mask;
        r_rpc     <= w_top_rpc;
        r_rpc_vld <= w_top_vld;
        r_depth   <= w_eff_depth - DW'(1);
      end else begin
        r_pc      <= w_npc;
        r_mask    <= w_nm;
        r_rpc     <= w_eff_rpc;
        r_rpc_vld <= w_eff_vld;
        r_depth   <= w_eff_depth;
      end
    end
  end

  // Stack storage carries no reset; only entries below r_depth are ever read.
  always_ff @(posedge clk) begin
    if (!rst && w_retire && w_diverge) begin
      r_stk_pc[w_idx_a]   <= i_reconv_pc;
      r_stk_mask[w_idx_a] <= r_mask;
      r_stk_rpc[w_idx_a]  <= r_rpc;
      r_stk_vld[w_idx_a]  <= r_rpc_vld;
      r_stk_pc[w_idx_b]   <= w_pc_plus4;
      r_stk_mask[w_idx_b] <= w_ntaken;
      r_stk_rpc[w_idx_b]  <= i_reconv_pc;
      r_stk_vld[w_idx_b]  <= 1'b1;
    end
  end

  assign o_pc          = r_pc;
  assign o_active_mask = r_mask;
  assign o_depth       = r_depth;
  assign o_halted      = r_halted;
  assign o_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_simt_warp_pc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_simt_warp_pc_unit
//  Purpose  : Self-checking bench for simt_warp_pc_unit. Two instances
//             (8-entry and 2-entry stacks) share one stimulus stream and are
//             compared each cycle against a stack-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simt_warp_pc_unit;

  logic        clk = 1'b0;
  logic        rst, adv, br_valid, jmp_valid, halt_req;
  logic [3:0]  br_taken;
  logic [31:0] br_target, reconv_pc, jmp_target;

  logic [31:0] pc_a, pc_b;
  logic [3:0]  mask_a, mask_b;
  logic [3:0]  depth_a;
  logic [1:0]  depth_b;
  logic        halted_a, halted_b, ovf_a, ovf_b;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  simt_warp_pc_unit #(.LANES(4), .STACK_DEPTH(8), .PC_INIT(32'h0)) u_dut_a (
    .clk(clk), .rst(rst), .i_adv(adv), .i_br_valid(br_valid), .i_br_taken(br_taken),
    .i_br_target(br_target), .i_reconv_pc(reconv_pc), .i_jmp_valid(jmp_valid),
    .i_jmp_target(jmp_target), .i_halt_req(halt_req), .o_pc(pc_a),
    .o_active_mask(mask_a), .o_depth(depth_a), .o_halted(halted_a), .o_overflow(ovf_a));

  simt_warp_pc_unit #(.LANES(4), .STACK_DEPTH(2), .PC_INIT(32'h0)) u_dut_b (
    .clk(clk), .rst(rst), .i_adv(adv), .i_br_valid(br_valid), .i_br_taken(br_taken),
    .i_br_target(br_target), .i_reconv_pc(reconv_pc), .i_jmp_valid(jmp_valid),
    .i_jmp_target(jmp_target), .i_halt_req(halt_req), .o_pc(pc_b),
    .o_active_mask(mask_b), .o_depth(depth_b), .o_halted(halted_b), .o_overflow(ovf_b));

  // ---------------- reference model (index 0: 8 entries, 1: 2 entries) ----
  int          cap [2] = '{8, 2};
  logic [31:0] m_pc [2];
  logic [3:0]  m_mask [2];
  logic [31:0] m_rpc [2];
  logic        m_vld [2];
  int          m_depth [2];
  logic        m_halted [2];
  logic        m_ovf [2];
  logic [31:0] s_pc [2][16];
  logic [3:0]  s_mask [2][16];
  logic [31:0] s_rpc [2][16];
  logic        s_vld [2][16];

  task automatic model_reset(input int k);
    m_pc[k] = 32'h0; m_mask[k] = 4'hF; m_rpc[k] = 32'h0; m_vld[k] = 1'b0;
    m_depth[k] = 0; m_halted[k] = 1'b0; m_ovf[k] = 1'b0;
  endtask

  task automatic push(input int k, input logic [31:0] p, input logic [3:0] m,
                      input logic [31:0] r, input logic v);
    s_pc[k][m_depth[k]] = p; s_mask[k][m_depth[k]] = m;
    s_rpc[k][m_depth[k]] = r; s_vld[k][m_depth[k]] = v;
    m_depth[k]++;
  endtask

  task automatic model_step(input int k);
    logic [31:0] npc, nrpc;
    logic [3:0]  nm, t, n;
    logic        nvld;
    if (m_halted[k] || !adv) return;
    if (halt_req) begin
      m_halted[k] = 1'b1;
      return;
    end
    npc = m_pc[k] + 32'd4; nm = m_mask[k]; nrpc = m_rpc[k]; nvld = m_vld[k];
    if (jmp_valid) begin
      npc = jmp_target;
    end else if (br_valid) begin
      t = br_taken & m_mask[k];
      n = m_mask[k] & ~t;
      if (t == 4'h0) npc = m_pc[k] + 32'd4;
      else if (n == 4'h0) npc = br_target;
      else if (m_depth[k] + 2 > cap[k]) begin
        m_ovf[k] = 1'b1; m_halted[k] = 1'b1;
        return;
      end else begin
        push(k, reconv_pc, m_mask[k], m_rpc[k], m_vld[k]);
        push(k, m_pc[k] + 32'd4, n, reconv_pc, 1'b1);
        npc = br_target; nm = t; nrpc = reconv_pc; nvld = 1'b1;
      end
    end
    if (nvld && npc == nrpc && m_depth[k] > 0) begin
      m_depth[k]--;
      m_pc[k]   = s_pc[k][m_depth[k]];
      m_mask[k] = s_mask[k][m_depth[k]];
      m_rpc[k]  = s_rpc[k][m_depth[k]];
      m_vld[k]  = s_vld[k][m_depth[k]];
    end else begin
      m_pc[k] = npc; m_mask[k] = nm; m_rpc[k] = nrpc; m_vld[k] = nvld;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("a_pc", pc_a, m_pc[0]);
    check("a_mask", {28'h0, mask_a}, {28'h0, m_mask[0]});
    check("a_depth", {28'h0, depth_a}, 32'(m_depth[0]));
    check("a_halted", {31'h0, halted_a}, {31'h0, m_halted[0]});
    check("a_ovf", {31'h0, ovf_a}, {31'h0, m_ovf[0]});
    check("b_pc", pc_b, m_pc[1]);
    check("b_mask", {28'h0, mask_b}, {28'h0, m_mask[1]});
    check("b_depth", {30'h0, depth_b}, 32'(m_depth[1]));
    check("b_halted", {31'h0, halted_b}, {31'h0, m_halted[1]});
    check("b_ovf", {31'h0, ovf_b}, {31'h0, m_ovf[1]});
  endtask

  task automatic tick();
    if (rst) begin
      model_reset(0); model_reset(1);
    end else begin
      model_step(0); model_step(1);
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic a, input logic bv, input logic [3:0] bt,
                       input logic [31:0] btg, input logic [31:0] rc,
                       input logic jv, input logic [31:0] jt, input logic h);
    adv = a; br_valid = bv; br_taken = bt; br_target = btg; reconv_pc = rc;
    jmp_valid = jv; jmp_target = jt; halt_req = h;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic plain();   drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0); tick(); endtask
  task automatic jump(input logic [31:0] t); drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, t, 1'b0); tick(); endtask
  task automatic branch(input logic [3:0] tk, input logic [31:0] t, input logic [31:0] rc);
    drive(1'b1, 1'b1, tk, t, rc, 1'b0, 32'h0, 1'b0); tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset state
    do_reset();
    check("rst_pc", pc_a, 32'h0);
    check("rst_mask", {28'h0, mask_a}, 32'hF);
    check("rst_depth", {28'h0, depth_a}, 32'h0);
    check("rst_halted", {31'h0, halted_a}, 32'h0);
    check("rst_ovf", {31'h0, ovf_a}, 32'h0);

    // Sequential fetch and hold
    plain(); check("seq_pc1", pc_a, 32'h4);
    plain(); check("seq_pc2", pc_a, 32'h8);
    plain(); check("seq_pc3", pc_a, 32'hC);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h100, 1'b0); tick();
    check("hold_pc", pc_a, 32'hC);
    plain(); check("seq_pc4", pc_a, 32'h10);

    // Uniform branches
    branch(4'hF, 32'h40, 32'h80);
    check("uni_taken_pc", pc_a, 32'h40);
    check("uni_taken_depth", {28'h0, depth_a}, 32'h0);
    jump(32'h10);
    branch(4'h0, 32'h40, 32'h80);
    check("uni_nt_pc", pc_a, 32'h14);

    // Divergence and reconvergence
    jump(32'h10);
    branch(4'b0011, 32'h40, 32'h20);
    check("div_pc", pc_a, 32'h40);
    check("div_mask", {28'h0, mask_a}, 32'h3);
    check("div_depth", {28'h0, depth_a}, 32'h2);
    jump(32'h20);
    check("pop1_pc", pc_a, 32'h14);
    check("pop1_mask", {28'h0, mask_a}, 32'hC);
    check("pop1_depth", {28'h0, depth_a}, 32'h1);
    plain(); plain(); plain();
    check("reconv_pc", pc_a, 32'h20);
    check("reconv_mask", {28'h0, mask_a}, 32'hF);
    check("reconv_depth", {28'h0, depth_a}, 32'h0);

    // Branch target equal to reconvergence PC: immediate fall-through
    branch(4'b0101, 32'h40, 32'h40);
    check("selfrc_pc", pc_a, 32'h24);
    check("selfrc_mask", {28'h0, mask_a}, 32'hA);
    check("selfrc_depth", {28'h0, depth_a}, 32'h1);

    // PC wraparound
    do_reset();
    jump(32'hFFFF_FFFC);
    plain(); check("wrap_pc", pc_a, 32'h0);

    // Overflow on the 2-entry instance with nested divergence
    do_reset();
    jump(32'h10);
    branch(4'b0011, 32'h40, 32'h20);
    branch(4'b0001, 32'h80, 32'h60);
    check("ovf_flag", {31'h0, ovf_b}, 32'h1);
    check("ovf_halted", {31'h0, halted_b}, 32'h1);
    check("ovf_pc", pc_b, 32'h40);
    check("nest_depth_a", {28'h0, depth_a}, 32'h4);
    for (int i = 0; i < 5; i++) plain();
    check("ovf_frozen_pc", pc_b, 32'h40);
    check("ovf_frozen_depth", {30'h0, depth_b}, 32'h2);
    do_reset();
    check("ovf_rst_flag", {31'h0, ovf_b}, 32'h0);
    check("ovf_rst_halted", {31'h0, halted_b}, 32'h0);

    // Halt wins over a divergent branch
    jump(32'h10);
    drive(1'b1, 1'b1, 4'b0011, 32'h40, 32'h20, 1'b0, 32'h0, 1'b1); tick();
    check("halt_flag", {31'h0, halted_a}, 32'h1);
    check("halt_depth", {28'h0, depth_a}, 32'h0);
    check("halt_pc", pc_a, 32'h10);
    plain(); check("halt_hold_pc", pc_a, 32'h10);

    // Reset in the middle of a divergence
    do_reset();
    jump(32'h10);
    branch(4'b0011, 32'h40, 32'h20);
    check("mid_depth", {28'h0, depth_a}, 32'h2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_depth", {28'h0, depth_a}, 32'h0);
    check("midrst_mask", {28'h0, mask_a}, 32'hF);
    check("midrst_pc", pc_a, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] tgt, rc;
      rst = ($urandom_range(0, 199) == 0) ||
            ((m_halted[0] || m_halted[1]) && $urandom_range(0, 3) == 0);
      rc  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      tgt = ($urandom_range(0, 2) == 0) ? m_rpc[0] : {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      drive(($urandom_range(0, 4) != 0),
            ($urandom_range(0, 9) < 4),
            4'($urandom_range(0, 15)),
            tgt, rc,
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 1) == 0) ? m_rpc[0] : {26'h0, 4'($urandom_range(0, 15)), 2'b00},
            ($urandom_range(0, 99) == 0));
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
